// File: rtl/rv_pkg.sv
// Shared definitions for the PC / redirect path.
//  - PCSEL_*  : encodings of the 2-bit next-PC decision from the branch unit
//  - state_e  : redirect FSM states
//  - is_word_aligned : true when an address is legal as a fetch target
package rv_pkg;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_BR   = 2'b01;
    localparam logic [1:0] PCSEL_JALR = 2'b10;
    localparam logic [1:0] PCSEL_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SQUASH = 2'b01,
        ST_HALT   = 2'b10
    } state_e;

    // Fetch targets must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//  clk   : clock, rising edge
//  rst   : synchronous active-high reset, clears count
//  clr   : synchronous clear
//  inc   : increment enable; count sticks at all-ones
//  count : current value
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner and redirect/squash controller.
//  clk, rst       : clock and synchronous active-high reset
//  stall          : holds PC on sequential advance
//  pc_sel         : next-PC decision (seq / branch-jal / jalr / halt)
//  br_target      : PC-relative target
//  jalr_target    : rs1+imm target (LSB cleared here)
//  pc             : current fetch PC (registered)
//  pc_plus4       : pc+4 (combinational)
//  flush_ifid     : squash IF/ID this cycle
//  flush_idex     : squash ID/EX this cycle
//  halted         : core halted, PC frozen until rst
//  misalign_err   : sticky, redirect target misaligned
//  redirect_count : accepted redirects, saturating
module pc_redirect_unit
    import rv_pkg::*;
#(
    parameter int unsigned       XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_PC     = '0,
    parameter int unsigned       FLUSH_CYCLES = 2,
    parameter int unsigned       CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  br_target,
    input  logic [XLEN-1:0]  jalr_target,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int unsigned     SQ_W    = 3;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(FLUSH_CYCLES - 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_d;
    logic [SQ_W-1:0] sq_cnt_q;
    logic [SQ_W-1:0] sq_cnt_d;
    logic            misalign_d;
    logic            redirect_acc;
    logic [XLEN-1:0] tgt;
    logic            tgt_ok;

    // Sequential successor; wraps naturally modulo 2^XLEN.
    assign pc_plus4 = pc + PC_STEP;

    // Effective redirect target; jalr drops bit 0 before the alignment check.
    assign tgt    = (pc_sel == PCSEL_JALR) ? (jalr_target & LSB_CLR) : br_target;
    assign tgt_ok = is_word_aligned(tgt[1:0]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, squash counter and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC;
            sq_cnt_q     <= '0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_d;
            sq_cnt_q     <= sq_cnt_d;
            misalign_err <= misalign_d;
        end
    end

    // Next-state / next-PC decision.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        sq_cnt_d     = sq_cnt_q;
        misalign_d   = misalign_err;
        redirect_acc = 1'b0;
        case (state_q)
            ST_RUN: begin
                case (pc_sel)
                    PCSEL_SEQ: begin
                        if (!stall) begin
                            pc_d = pc_plus4;
                        end
                    end
                    PCSEL_BR, PCSEL_JALR: begin
                        if (tgt_ok) begin
                            // A taken redirect wins over a stall.
                            pc_d         = tgt;
                            redirect_acc = 1'b1;
                            if (FLUSH_CYCLES > 1) begin
                                state_d  = ST_SQUASH;
                                sq_cnt_d = SQ_LOAD;
                            end
                        end else begin
                            misalign_d = 1'b1;
                            state_d    = ST_HALT;
                        end
                    end
                    default: begin
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_SQUASH: begin
                // pc_sel here belongs to a wrong-path instruction and is ignored.
                if (!stall) begin
                    pc_d = pc_plus4;
                end
                sq_cnt_d = sq_cnt_q - SQ_W'(1);
                if (sq_cnt_q == SQ_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Flush / halt outputs.
    always_comb begin
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pc_sel != PCSEL_SEQ) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            ST_SQUASH: begin
                flush_ifid = 1'b1;
            end
            ST_HALT: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                flush_ifid = 1'b0;
            end
        endcase
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (redirect_acc),
        .count (redirect_count)
    );

endmodule
